rvfi_imem_track_check: RTL and testbench
========================================

Name: rvfi_imem_track_check

Overview:
- Parametrised successor to the single-address instruction-memory consistency check.
- Tracks NSLOT solver-chosen halfword addresses and checks every retired instruction fetch that covers a tracked halfword against its expected value.
- Adds a learn mode: the first fetch of a halfword defines its expected value.
- Models store-then-fence.i coherence: a store marks the slot pending; the merged data becomes expected after fence.i.
- Sits beside the RVFI wrapper in formal and simulation harnesses.

Parameters:
XLEN, 32, RVFI register/address width (32 or 64)
ILEN, 32, RVFI instruction width
NRET, 1, retire channels per cycle
NSLOT, 2, number of tracked halfword addresses (1..8)
LEARN, 1, 1 = expected data learned from first fetch; 0 = expected data is a solver-chosen constant
ASSERT_EN, 1, 1 = emit an immediate assert on each mismatch in addition to the err flag

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  check enable; when low, no checks and no state updates
rvfi_valid  input  NRET  retire valid per channel
rvfi_pc_rdata  input  NRET*XLEN  PC per channel
rvfi_insn  input  NRET*ILEN  instruction word per channel
rvfi_mem_addr  input  NRET*XLEN  memory address per channel, XLEN/8-aligned
rvfi_mem_wmask  input  NRET*XLEN/8  byte write mask per channel
rvfi_mem_wdata  input  NRET*XLEN  write data per channel
slot_addr  output  NSLOT*XLEN  constant random addresses, bit0 forced 0
slot_data  output  NSLOT*16  current expected halfword per slot
slot_state  output  NSLOT*2  per slot: 0 EMPTY, 1 VALID, 2 PENDING
err  output  1  sticky mismatch flag
err_slot  output  NSLOT  sticky per-slot mismatch flags

Behaviour:
- Clock and reset: one clock (clock). Reset is synchronous and active-high.
- Reset state:
  - LEARN=1: every slot EMPTY, slot_data=0.
  - LEARN=0: every slot VALID, slot_data = its constant random value.
  - In both modes: err=0, err_slot=0, shadow=0.
  - Reset mid-operation discards all learned and pending data.
- Channel order: channels are processed 0..NRET-1 within one cycle, sequentially. Updates from channel k are visible to channel k+1 in the same cycle.
- Per-channel processing, for each valid channel with enable high, in this order: (a) fetch check, (b) store, (c) fence.i.
- Fetch match:
  - Low halfword matches slot s when rvfi_addr_valid(pc) and pc == slot_addr[s].
  - High halfword matches when insn[1:0] == 2'b11, rvfi_addr_valid(pc+2) and pc+2 == slot_addr[s].
  - pc+2 wraps modulo 2^XLEN.
- Fetch check, by slot state:
  - VALID: compare the fetched halfword to slot_data. On mismatch, set err_slot[s] and err.
  - EMPTY (LEARN=1): slot_data <= fetched halfword, slot -> VALID, no error.
  - PENDING: no check, no state change.
- Store:
  - Byte k of the store hits the slot if wmask[k]=1 and mem_addr+k equals slot_addr or slot_addr+1.
  - Any hit in VALID or PENDING: merge hit bytes into a shadow halfword (shadow starts from slot_data on the VALID->PENDING transition); slot -> PENDING.
  - Hit in EMPTY: ignored.
- fence.i: insn[6:0]=7'b0001111 with insn[14:12]=3'b001. Every PENDING slot -> VALID with slot_data <= shadow.
- Timing: err and err_slot assert the cycle after the offending retire and hold until reset. slot_state and slot_data update on the same edge.
- Assertions: ASSERT_EN=1 places an assert at each mismatch point, evaluated only outside reset.
- Slot address collisions: two slots with the same address are allowed and behave independently.

Test Plan:
- LEARN=1, slot0=0x100. Retire pc=0x100 insn=0x00A00093. Then retire pc=0x100 insn=0x00B00093 -> slot0 VALID, data 0x0093 after the first retire; second retire gives no error (low halfwords equal). Third retire pc=0x100 insn=0x00000013 -> err=1 and err_slot=1 one cycle later.
- LEARN=1, slot1=0x102. Retire pc=0x100, 32-bit insn 0x12345013 -> slot1 learns 0x1234. Compressed insn 0x4501 at pc=0x100 -> slot1 unaffected.
- Slot0=0x200 VALID with 0x0513. Store mem_addr=0x200, wmask=0b0001, wdata=0xFF -> PENDING. Fetch 0x0000 at 0x200 -> no error. fence.i -> VALID with 0x05FF. Fetch 0x0513 -> err.
- NRET=2: channel0 stores to slot0, channel1 fetches slot0 in the same cycle -> no check (PENDING seen by channel1).
- enable=0 during a mismatching fetch -> err stays 0. Reset asserted while PENDING -> next cycle EMPTY (LEARN=1) and err=0.
- LEARN=0: fetch of a halfword differing from slot_data at slot_addr -> err; fetch at slot_addr+4 -> no effect.

Source files
------------

// File: rtl/rvfi_imem_track_check_if.sv
// Retire-bus bundle carrying the RVFI signals the instruction-memory tracker
// needs. The harness side drives it (master); the checker observes it (slave).
interface rvfi_imem_track_check_if #(
   parameter int XLEN = 32,
   parameter int ILEN = 32,
   parameter int NRET = 1
);
   logic [NRET-1:0]        rvfi_valid;
   logic [NRET*XLEN-1:0]   rvfi_pc_rdata;
   logic [NRET*ILEN-1:0]   rvfi_insn;
   logic [NRET*XLEN-1:0]   rvfi_mem_addr;
   logic [NRET*XLEN/8-1:0] rvfi_mem_wmask;
   logic [NRET*XLEN-1:0]   rvfi_mem_wdata;

   modport master (
      output rvfi_valid, rvfi_pc_rdata, rvfi_insn,
             rvfi_mem_addr, rvfi_mem_wmask, rvfi_mem_wdata
   );

   modport slave (
      input rvfi_valid, rvfi_pc_rdata, rvfi_insn,
            rvfi_mem_addr, rvfi_mem_wmask, rvfi_mem_wdata
   );
endinterface

// File: rtl/rvfi_imem_track_check.sv
// Instruction-memory consistency checker for NSLOT tracked halfwords.
// Every retired fetch covering a tracked halfword is compared against the
// slot's expected value. Stores to a tracked halfword park the merged data
// in a shadow copy that only becomes the expected value after fence.i.
// The tracked addresses (and, without learning, the expected data) are
// constants; a formal harness binds them to solver-chosen values.
module rvfi_imem_track_check #(
   parameter int XLEN      = 32,
   parameter int ILEN      = 32,
   parameter int NRET      = 1,
   parameter int NSLOT     = 2,
   parameter int LEARN     = 1,
   parameter int ASSERT_EN = 1,
   parameter logic [NSLOT*XLEN-1:0] SLOT_ADDR = '0,
   parameter logic [NSLOT*16-1:0]   SLOT_DATA = '0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    enable,
   rvfi_imem_track_check_if.slave  rvfi,
   output logic [NSLOT*XLEN-1:0]   slot_addr,
   output logic [NSLOT*16-1:0]     slot_data,
   output logic [NSLOT*2-1:0]      slot_state,
   output logic                    err,
   output logic [NSLOT-1:0]        err_slot
);

   typedef enum logic [1:0] {
      S_EMPTY   = 2'd0,
      S_VALID   = 2'd1,
      S_PENDING = 2'd2
   } slotState_t;

   // 64-bit harts use Sv39 canonical addresses; 32-bit harts accept any address.
   localparam int VA_BITS = (XLEN == 64) ? 39 : XLEN;

   slotState_t       r_state  [NSLOT];
   logic [15:0]      r_data   [NSLOT];
   logic [15:0]      r_shadow [NSLOT];
   logic             r_err;
   logic [NSLOT-1:0] r_errSlot;

   slotState_t       w_state    [NSLOT];
   logic [15:0]      w_data     [NSLOT];
   logic [15:0]      w_shadow   [NSLOT];
   logic [NSLOT-1:0] w_errHit;
   logic [XLEN-1:0]  w_slotAddr [NSLOT];

   // An address is usable when the bits above the virtual range are a sign extension.
   function automatic logic rvfiAddrValid(input logic [XLEN-1:0] addr);
      logic [XLEN-1:0] top;
      top = addr >> (VA_BITS - 1);
      return (top == '0) || (top == ({XLEN{1'b1}} >> (VA_BITS - 1)));
   endfunction

   // Tracked addresses are halfword aligned, so bit 0 is always dropped.
   for (genvar s = 0; s < NSLOT; s++) begin : g_slot
      assign w_slotAddr[s]              = {SLOT_ADDR[s*XLEN+1 +: XLEN-1], 1'b0};
      assign slot_addr[s*XLEN +: XLEN]  = w_slotAddr[s];
      assign slot_data[s*16 +: 16]      = r_data[s];
      assign slot_state[s*2 +: 2]       = r_state[s];
   end

   assign err      = r_err;
   assign err_slot = r_errSlot;

   // Walk the retire channels in order so a later channel sees the slot
   // updates of an earlier one; each channel does fetch check, store, fence.i.
   always_comb begin : p_next
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   pcHi;
      logic [XLEN-1:0]   memAddr;
      logic [XLEN-1:0]   byteAddr;
      logic [XLEN-1:0]   wdata;
      logic [XLEN/8-1:0] wmask;
      logic [ILEN-1:0]   insn;
      logic [15:0]       fetchHw;
      logic [15:0]       merged;
      logic              fetchHit;
      logic              storeHit;

      w_state  = r_state;
      w_data   = r_data;
      w_shadow = r_shadow;
      w_errHit = '0;
      pc       = '0;
      pcHi     = '0;
      memAddr  = '0;
      byteAddr = '0;
      wdata    = '0;
      wmask    = '0;
      insn     = '0;
      fetchHw  = '0;
      merged   = '0;
      fetchHit = 1'b0;
      storeHit = 1'b0;

      if (enable) begin
         for (int c = 0; c < NRET; c++) begin
            if (rvfi.rvfi_valid[c]) begin
               pc      = rvfi.rvfi_pc_rdata[c*XLEN +: XLEN];
               pcHi    = pc + XLEN'(2);
               insn    = rvfi.rvfi_insn[c*ILEN +: ILEN];
               memAddr = rvfi.rvfi_mem_addr[c*XLEN +: XLEN];
               wmask   = rvfi.rvfi_mem_wmask[c*(XLEN/8) +: XLEN/8];
               wdata   = rvfi.rvfi_mem_wdata[c*XLEN +: XLEN];

               for (int s = 0; s < NSLOT; s++) begin
                  fetchHit = 1'b0;
                  fetchHw  = '0;
                  if (rvfiAddrValid(pc) && (pc == w_slotAddr[s])) begin
                     fetchHit = 1'b1;
                     fetchHw  = insn[15:0];
                  end else if ((insn[1:0] == 2'b11) && rvfiAddrValid(pcHi) &&
                               (pcHi == w_slotAddr[s])) begin
                     fetchHit = 1'b1;
                     fetchHw  = insn[31:16];
                  end
                  if (fetchHit) begin
                     case (w_state[s])
                        S_VALID: begin
                           if (fetchHw != w_data[s]) begin
                              w_errHit[s] = 1'b1;
                           end
                        end
                        S_EMPTY: begin
                           if (LEARN != 0) begin
                              w_data[s]  = fetchHw;
                              w_state[s] = S_VALID;
                           end
                        end
                        default: begin
                        end
                     endcase
                  end
               end

               for (int s = 0; s < NSLOT; s++) begin
                  storeHit = 1'b0;
                  merged   = (w_state[s] == S_VALID) ? w_data[s] : w_shadow[s];
                  for (int k = 0; k < XLEN/8; k++) begin
                     byteAddr = memAddr + XLEN'(k);
                     if (wmask[k] && (byteAddr == w_slotAddr[s])) begin
                        storeHit     = 1'b1;
                        merged[7:0]  = wdata[k*8 +: 8];
                     end
                     if (wmask[k] && (byteAddr == w_slotAddr[s] + XLEN'(1))) begin
                        storeHit     = 1'b1;
                        merged[15:8] = wdata[k*8 +: 8];
                     end
                  end
                  if (storeHit && (w_state[s] != S_EMPTY)) begin
                     w_shadow[s] = merged;
                     w_state[s]  = S_PENDING;
                  end
               end

               if ((insn[6:0] == 7'b0001111) && (insn[14:12] == 3'b001)) begin
                  for (int s = 0; s < NSLOT; s++) begin
                     if (w_state[s] == S_PENDING) begin
                        w_state[s] = S_VALID;
                        w_data[s]  = w_shadow[s];
                     end
                  end
               end
            end
         end
      end
   end

   // Register slot contents and accumulate the sticky error flags.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int s = 0; s < NSLOT; s++) begin
            r_state[s]  <= (LEARN != 0) ? S_EMPTY : S_VALID;
            r_data[s]   <= (LEARN != 0) ? 16'h0000 : SLOT_DATA[s*16 +: 16];
            r_shadow[s] <= '0;
         end
         r_err     <= 1'b0;
         r_errSlot <= '0;
      end else begin
         r_state   <= w_state;
         r_data    <= w_data;
         r_shadow  <= w_shadow;
         r_errSlot <= r_errSlot | w_errHit;
         r_err     <= r_err | (|w_errHit);
      end
   end

   if (ASSERT_EN != 0) begin : g_assert
      // Flag any fetch mismatch immediately, ignoring cycles held in reset.
      always_ff @(posedge clock) begin
         if (!reset) begin
            assert (w_errHit == '0);
         end
      end
   end

endmodule

// File: tb/tb_rvfi_imem_track_check.sv
// Directed bench for the instruction-memory tracker. Three instances cover
// learn mode with one channel, learn mode with two channels and constant mode.
module tb_rvfi_imem_track_check;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b1;
   int   testsRun = 0;
   int   testsFailed = 0;

   always #5 clock = ~clock;

   rvfi_imem_track_check_if #(.XLEN(32), .ILEN(32), .NRET(1)) ifA ();
   rvfi_imem_track_check_if #(.XLEN(32), .ILEN(32), .NRET(2)) ifB ();
   rvfi_imem_track_check_if #(.XLEN(32), .ILEN(32), .NRET(1)) ifC ();

   logic [63:0] addrA;
   logic [31:0] dataA;
   logic [3:0]  stateA;
   logic        errA;
   logic [1:0]  errSlotA;
   logic [63:0] addrB;
   logic [31:0] dataB;
   logic [3:0]  stateB;
   logic        errB;
   logic [1:0]  errSlotB;
   logic [31:0] addrC;
   logic [15:0] dataC;
   logic [1:0]  stateC;
   logic        errC;
   logic [0:0]  errSlotC;

   // slot0 = 0x100, slot1 = 0x200
   rvfi_imem_track_check #(
      .XLEN(32), .ILEN(32), .NRET(1), .NSLOT(2), .LEARN(1), .ASSERT_EN(0),
      .SLOT_ADDR({32'h0000_0200, 32'h0000_0100}), .SLOT_DATA(32'h0)
   ) dutA (
      .clock(clock), .reset(reset), .enable(enable), .rvfi(ifA),
      .slot_addr(addrA), .slot_data(dataA), .slot_state(stateA),
      .err(errA), .err_slot(errSlotA)
   );

   // slot0 = 0x200, slot1 = 0x102, two retire channels
   rvfi_imem_track_check #(
      .XLEN(32), .ILEN(32), .NRET(2), .NSLOT(2), .LEARN(1), .ASSERT_EN(0),
      .SLOT_ADDR({32'h0000_0102, 32'h0000_0200}), .SLOT_DATA(32'h0)
   ) dutB (
      .clock(clock), .reset(reset), .enable(enable), .rvfi(ifB),
      .slot_addr(addrB), .slot_data(dataB), .slot_state(stateB),
      .err(errB), .err_slot(errSlotB)
   );

   // constant mode; odd address parameter must read back halfword aligned
   rvfi_imem_track_check #(
      .XLEN(32), .ILEN(32), .NRET(1), .NSLOT(1), .LEARN(0), .ASSERT_EN(0),
      .SLOT_ADDR(32'h0000_0301), .SLOT_DATA(16'hABCD)
   ) dutC (
      .clock(clock), .reset(reset), .enable(enable), .rvfi(ifC),
      .slot_addr(addrC), .slot_data(dataC), .slot_state(stateC),
      .err(errC), .err_slot(errSlotC)
   );

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic applyReset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic applyStimulusA(input logic [31:0] pc, input logic [31:0] insn,
                                 input logic [31:0] maddr, input logic [3:0] wmask,
                                 input logic [31:0] wdata);
      @(negedge clock);
      ifA.rvfi_valid     = 1'b1;
      ifA.rvfi_pc_rdata  = pc;
      ifA.rvfi_insn      = insn;
      ifA.rvfi_mem_addr  = maddr;
      ifA.rvfi_mem_wmask = wmask;
      ifA.rvfi_mem_wdata = wdata;
      @(negedge clock);
      ifA.rvfi_valid     = 1'b0;
      ifA.rvfi_mem_wmask = '0;
   endtask

   task automatic applyStimulusB(input logic [1:0] valid, input logic [63:0] pc,
                                 input logic [63:0] insn, input logic [63:0] maddr,
                                 input logic [7:0] wmask, input logic [63:0] wdata);
      @(negedge clock);
      ifB.rvfi_valid     = valid;
      ifB.rvfi_pc_rdata  = pc;
      ifB.rvfi_insn      = insn;
      ifB.rvfi_mem_addr  = maddr;
      ifB.rvfi_mem_wmask = wmask;
      ifB.rvfi_mem_wdata = wdata;
      @(negedge clock);
      ifB.rvfi_valid     = '0;
      ifB.rvfi_mem_wmask = '0;
   endtask

   task automatic applyStimulusC(input logic [31:0] pc, input logic [31:0] insn);
      @(negedge clock);
      ifC.rvfi_valid     = 1'b1;
      ifC.rvfi_pc_rdata  = pc;
      ifC.rvfi_insn      = insn;
      ifC.rvfi_mem_addr  = '0;
      ifC.rvfi_mem_wmask = '0;
      ifC.rvfi_mem_wdata = '0;
      @(negedge clock);
      ifC.rvfi_valid     = 1'b0;
   endtask

   initial begin
      ifA.rvfi_valid = '0; ifA.rvfi_pc_rdata = '0; ifA.rvfi_insn = '0;
      ifA.rvfi_mem_addr = '0; ifA.rvfi_mem_wmask = '0; ifA.rvfi_mem_wdata = '0;
      ifB.rvfi_valid = '0; ifB.rvfi_pc_rdata = '0; ifB.rvfi_insn = '0;
      ifB.rvfi_mem_addr = '0; ifB.rvfi_mem_wmask = '0; ifB.rvfi_mem_wdata = '0;
      ifC.rvfi_valid = '0; ifC.rvfi_pc_rdata = '0; ifC.rvfi_insn = '0;
      ifC.rvfi_mem_addr = '0; ifC.rvfi_mem_wmask = '0; ifC.rvfi_mem_wdata = '0;

      // Reset state of all three instances
      applyReset();
      checkOutput("rstA_state", stateA, 4'b0000);
      checkOutput("rstA_data", dataA, 32'h0);
      checkOutput("rstA_err", errA, 1'b0);
      checkOutput("rstA_addr", addrA, 64'h0000_0200_0000_0100);
      checkOutput("rstC_state", stateC, 2'b01);
      checkOutput("rstC_data", dataC, 16'hABCD);
      checkOutput("rstC_addr", addrC, 32'h0000_0300);

      // Learn on first fetch, equal low halfword passes, different one fails
      applyStimulusA(32'h100, 32'h00A0_0093, 32'h0, 4'b0000, 32'h0);
      checkOutput("learn_state", stateA, 4'b0001);
      checkOutput("learn_data", dataA, 32'h0000_0093);
      applyStimulusA(32'h100, 32'h00B0_0093, 32'h0, 4'b0000, 32'h0);
      checkOutput("sameLow_err", errA, 1'b0);
      applyStimulusA(32'h100, 32'h0000_0013, 32'h0, 4'b0000, 32'h0);
      checkOutput("mismatch_err", errA, 1'b1);
      checkOutput("mismatch_errSlot", errSlotA, 2'b01);

      // Store marks pending, fence.i commits the merged halfword
      applyReset();
      checkOutput("rst2_err", errA, 1'b0);
      applyStimulusA(32'h200, 32'h0000_0513, 32'h0, 4'b0000, 32'h0);
      checkOutput("learn200_data", dataA, 32'h0513_0000);
      applyStimulusA(32'h400, 32'h0000_0023, 32'h200, 4'b0001, 32'h0000_00FF);
      checkOutput("store_state", stateA, 4'b1000);
      checkOutput("store_data", dataA, 32'h0513_0000);
      applyStimulusA(32'h402, 32'h0000_0023, 32'h200, 4'b0100, 32'h00EE_0000);
      applyStimulusA(32'h200, 32'h0000_0000, 32'h0, 4'b0000, 32'h0);
      checkOutput("pendFetch_err", errA, 1'b0);
      applyStimulusA(32'h404, 32'h0000_100F, 32'h0, 4'b0000, 32'h0);
      checkOutput("fence_state", stateA, 4'b0100);
      checkOutput("fence_data", dataA, 32'h05FF_0000);
      applyStimulusA(32'h200, 32'h0000_0513, 32'h0, 4'b0000, 32'h0);
      checkOutput("postFence_errSlot", errSlotA, 2'b10);

      // enable low suppresses checks and learning
      applyReset();
      applyStimulusA(32'h100, 32'h00A0_0093, 32'h0, 4'b0000, 32'h0);
      enable = 1'b0;
      applyStimulusA(32'h100, 32'h0000_0013, 32'h0, 4'b0000, 32'h0);
      applyStimulusA(32'h200, 32'h0000_0513, 32'h0, 4'b0000, 32'h0);
      checkOutput("disabled_err", errA, 1'b0);
      checkOutput("disabled_state", stateA, 4'b0001);
      enable = 1'b1;

      // High halfword of a 32-bit fetch learns slot1; compressed fetch does not reach it
      applyReset();
      applyStimulusB(2'b01, 64'h100, 64'h1234_5013, 64'h0, 8'h00, 64'h0);
      checkOutput("hiLearn_state", stateB, 4'b0100);
      checkOutput("hiLearn_data", dataB, 32'h1234_0000);
      applyStimulusB(2'b01, 64'h100, 64'h0000_4501, 64'h0, 8'h00, 64'h0);
      checkOutput("compr_data", dataB, 32'h1234_0000);
      checkOutput("compr_err", errB, 1'b0);

      // Channel 1 sees channel 0's learned value in the same cycle
      applyReset();
      applyStimulusB(2'b11, {32'h100, 32'h100}, {32'h5678_5013, 32'h1234_5013},
                     64'h0, 8'h00, 64'h0);
      checkOutput("sameCycleLearn_errSlot", errSlotB, 2'b10);

      // Channel 0 store makes slot pending before channel 1's fetch
      applyReset();
      applyStimulusB(2'b01, 64'h200, 64'h0000_0513, 64'h0, 8'h00, 64'h0);
      applyStimulusB(2'b11, {32'h200, 32'h400}, {32'h0000_0000, 32'h0000_0023},
                     {32'h0, 32'h200}, 8'h01, {32'h0, 32'h0000_00FF});
      checkOutput("dualCh_state", stateB, 4'b0010);
      checkOutput("dualCh_err", errB, 1'b0);

      // Reset while pending discards everything
      applyReset();
      checkOutput("rstPend_state", stateB, 4'b0000);
      checkOutput("rstPend_data", dataB, 32'h0);
      checkOutput("rstPend_err", errB, 1'b0);

      // Constant mode: off-slot fetch ignored, matching high half ok, mismatch flagged
      applyStimulusC(32'h304, 32'h0000_0001);
      checkOutput("constOff_err", errC, 1'b0);
      applyStimulusC(32'h2FE, 32'hABCD_0013);
      checkOutput("constHi_err", errC, 1'b0);
      applyStimulusC(32'h300, 32'h0000_0001);
      checkOutput("constMis_err", errC, 1'b1);
      checkOutput("constMis_errSlot", errSlotC, 1'b1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
